stereo_disparity_calc: RTL and testbench

- Consumes the two calculation buffers written by the left and right camera capture stages: 79x16 windows of 3-bit pixels, row-major, 11-bit address, addr = row*79 + col.
- On each start, scans both buffers in lockstep and finds the first dark column in every row of each image.
- Averages the per-row horizontal offset (left minus right) over the rows where both images have a dark column, and emits one signed disparity word for the distance stage downstream.

---
 rtl/stereo_disparity_calc_pkg.sv | 34 +++
 rtl/stereo_disparity_calc_seq_udiv.sv | 84 ++++++++
 rtl/stereo_disparity_calc.sv | 220 ++++++++++++++++++++++
 tb/tb_stereo_disparity_calc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_disparity_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stereo_disparity_calc_pkg
// Purpose  : Shared calc-window geometry, result widths and FSM encoding.
// Revision : 1.0
// ============================================================================
package stereo_disparity_calc_pkg;

    localparam int WIDTH  = 79;
    localparam int HEIGHT = 16;
    localparam int ADDR_W = 11;
    localparam int PIX_W  = 3;
    localparam int COL_W  = 7;
    localparam int DISP_W = 8;
    localparam int SUM_W  = 12;
    localparam int ROWS_W = 5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DIVIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [SUM_W-1:0] abs_sum(input logic [SUM_W-1:0] s);
        return s[SUM_W-1] ? -s : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stereo_disparity_calc_seq_udiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_udiv
// Purpose  : Unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module seq_udiv
    import stereo_disparity_calc_pkg::*;
#(
    parameter int N_W = SUM_W,
    parameter int D_W = ROWS_W,
    parameter int Q_W = DISP_W
) (
    input  logic           sysclk,
    input  logic           resetc,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [Q_W-1:0] quotient
);
    localparam int CNT_W = $clog2(N_W);

    logic [D_W-1:0]   r_rem;
    logic [D_W-1:0]   r_div;
    logic [N_W-1:0]   r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [D_W-1:0]   w_rem_in;
    logic [D_W-1:0]   w_div_in;
    logic [N_W-1:0]   w_quo_in;
    logic [D_W:0]     w_shift;
    logic [D_W:0]     w_diff;
    logic             w_ge;
    logic [D_W-1:0]   w_rem_next;
    logic [N_W-1:0]   w_quo_next;

    // The start cycle already performs the first step, so N_W cycles in total.
    always_comb begin
        w_rem_in   = start ? '0 : r_rem;
        w_quo_in   = start ? dividend : r_quo;
        w_div_in   = start ? divisor : r_div;
        w_shift    = {w_rem_in, w_quo_in[N_W-1]};
        w_ge       = (w_shift >= {1'b0, w_div_in});
        w_diff     = w_shift - {1'b0, w_div_in};
        w_rem_next = w_ge ? w_diff[D_W-1:0] : w_shift[D_W-1:0];
        w_quo_next = {w_quo_in[N_W-2:0], w_ge};
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_div  <= w_div_in;
                r_cnt  <= CNT_W'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(N_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_quo[Q_W-1:0];

endmodule
`default_nettype wire

// File: rtl/stereo_disparity_calc.sv
`default_nettype none
// ============================================================================
// Module   : stereo_disparity_calc
// Purpose  : Scans both calc buffers, averages per-row dark-column offset.
// Revision : 1.0
// ============================================================================
module stereo_disparity_calc
    import stereo_disparity_calc_pkg::*;
#(
    parameter int THRESH   = 3,
    parameter int RD_LAT   = 2,
    parameter int MIN_ROWS = 8
) (
    input  logic              sysclk,
    input  logic              resetc,
    input  logic              start,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              rden,
    input  logic [PIX_W-1:0]  q_left,
    input  logic [PIX_W-1:0]  q_right,
    output logic              busy,
    output logic              disp_valid,
    output logic [DISP_W-1:0] disparity,
    output logic [ROWS_W-1:0] rows_used,
    output logic              disp_ok
);
    localparam int DRAIN_W = $clog2(RD_LAT + 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_div_start;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_rden;
    logic [COL_W-1:0]    r_col;
    logic [DRAIN_W-1:0]  r_drain;
    logic [COL_W-1:0]    r_tag_col [RD_LAT];
    logic                r_tag_vld [RD_LAT];

    logic                r_found_l;
    logic                r_found_r;
    logic [COL_W-1:0]    r_col_l;
    logic [COL_W-1:0]    r_col_r;
    logic [SUM_W-1:0]    r_sum;
    logic [ROWS_W-1:0]   r_rows;

    logic                r_busy;
    logic                r_disp_valid;
    logic [DISP_W-1:0]   r_disparity;
    logic [ROWS_W-1:0]   r_rows_used;
    logic                r_disp_ok;

    logic [COL_W-1:0]    w_tcol;
    logic                w_tvld;
    logic                w_fl;
    logic                w_fr;
    logic [COL_W-1:0]    w_cl;
    logic [COL_W-1:0]    w_cr;
    logic [SUM_W-1:0]    w_d;
    logic                w_ok;
    logic                w_div_done;
    logic [DISP_W-1:0]   w_quo;
    logic [DISP_W-1:0]   w_disp;

    always_comb begin
        w_tcol = r_tag_col[RD_LAT-1];
        w_tvld = r_tag_vld[RD_LAT-1];
        w_fl   = r_found_l | (q_left  <= PIX_W'(THRESH));
        w_fr   = r_found_r | (q_right <= PIX_W'(THRESH));
        w_cl   = r_found_l ? r_col_l : w_tcol;
        w_cr   = r_found_r ? r_col_r : w_tcol;
        w_d    = SUM_W'(w_cl) - SUM_W'(w_cr);
        w_ok   = (r_rows >= ROWS_W'(MIN_ROWS));
        w_disp = r_sum[SUM_W-1] ? -w_quo : w_quo;
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_div_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next   = ST_SCAN;
                    w_accept = 1'b1;
                end
            end
            ST_SCAN: begin
                if (r_addr == LAST_ADDR) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // One cycle past RD_LAT so the final end-of-row update has landed.
                if (r_drain == DRAIN_W'(RD_LAT)) begin
                    if (w_ok) begin
                        w_next      = ST_DIVIDE;
                        w_div_start = 1'b1;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (w_div_done) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            r_addr  <= '0;
            r_rden  <= 1'b0;
            r_col   <= '0;
            r_drain <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_col[i] <= '0;
                r_tag_vld[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_rden <= 1'b1;
                r_addr <= '0;
                r_col  <= '0;
            end else if (r_state == ST_SCAN) begin
                if (r_addr == LAST_ADDR) begin
                    r_rden <= 1'b0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_col  <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
                end
            end
            r_drain      <= (r_state == ST_DRAIN) ? r_drain + DRAIN_W'(1) : '0;
            r_tag_col[0] <= r_col;
            r_tag_vld[0] <= r_rden;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_col[i] <= r_tag_col[i-1];
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            r_found_l <= 1'b0;
            r_found_r <= 1'b0;
            r_col_l   <= '0;
            r_col_r   <= '0;
            r_sum     <= '0;
            r_rows    <= '0;
        end else if (w_accept) begin
            r_found_l <= 1'b0;
            r_found_r <= 1'b0;
            r_sum     <= '0;
            r_rows    <= '0;
        end else if (w_tvld) begin
            if (w_tcol == LAST_COL) begin
                r_found_l <= 1'b0;
                r_found_r <= 1'b0;
                if (w_fl && w_fr) begin
                    r_sum  <= r_sum + w_d;
                    r_rows <= r_rows + ROWS_W'(1);
                end
            end else begin
                r_found_l <= w_fl;
                r_found_r <= w_fr;
                r_col_l   <= w_cl;
                r_col_r   <= w_cr;
            end
        end
    end

    always_ff @(posedge sysclk or negedge resetc) begin
        if (!resetc) begin
            r_busy       <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disparity  <= '0;
            r_rows_used  <= '0;
            r_disp_ok    <= 1'b0;
        end else begin
            r_busy       <= (w_next == ST_SCAN) || (w_next == ST_DRAIN) || (w_next == ST_DIVIDE);
            r_disp_valid <= (w_next == ST_DONE);
            if (w_next == ST_DONE) begin
                r_rows_used <= r_rows;
                r_disp_ok   <= w_ok;
                r_disparity <= w_ok ? w_disp : '0;
            end
        end
    end

    seq_udiv #(
        .N_W (SUM_W),
        .D_W (ROWS_W),
        .Q_W (DISP_W)
    ) u_div (
        .sysclk   (sysclk),
        .resetc   (resetc),
        .start    (w_div_start),
        .dividend (abs_sum(r_sum)),
        .divisor  (r_rows),
        .done     (w_div_done),
        .quotient (w_quo)
    );

    assign rdaddr     = r_addr;
    assign rden       = r_rden;
    assign busy       = r_busy;
    assign disp_valid = r_disp_valid;
    assign disparity  = r_disparity;
    assign rows_used  = r_rows_used;
    assign disp_ok    = r_disp_ok;

endmodule
`default_nettype wire

// File: tb/tb_stereo_disparity_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_stereo_disparity_calc
// Purpose  : Directed and random images checked against a row-scan reference.
// Revision : 1.0
// ============================================================================
module tb_stereo_disparity_calc;
    localparam int W      = 79;
    localparam int H      = 16;
    localparam int N      = W * H;
    localparam int RD_LAT = 2;

    logic        sysclk  = 1'b0;
    logic        resetc  = 1'b0;
    logic        start   = 1'b0;
    logic [10:0] rdaddr;
    logic        rden;
    logic [2:0]  q_left  = '0;
    logic [2:0]  q_right = '0;
    logic        busy;
    logic        disp_valid;
    logic [7:0]  disparity;
    logic [4:0]  rows_used;
    logic        disp_ok;

    logic [2:0]  mem_l [N];
    logic [2:0]  mem_r [N];
    logic [2:0]  s1_l = '0;
    logic [2:0]  s1_r = '0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_disp;
    int   exp_rows;
    int   exp_ok;
    int   exp_lat;

    always #5 sysclk = ~sysclk;

    stereo_disparity_calc dut (
        .sysclk     (sysclk),
        .resetc     (resetc),
        .start      (start),
        .rdaddr     (rdaddr),
        .rden       (rden),
        .q_left     (q_left),
        .q_right    (q_right),
        .busy       (busy),
        .disp_valid (disp_valid),
        .disparity  (disparity),
        .rows_used  (rows_used),
        .disp_ok    (disp_ok)
    );

    // Two-stage synchronous read, matching the calc RAM read latency.
    always @(posedge sysclk) begin
        if (rden) begin
            s1_l <= mem_l[int'(rdaddr)];
            s1_r <= mem_r[int'(rdaddr)];
        end
        q_left  <= s1_l;
        q_right <= s1_r;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_bright();
        for (int i = 0; i < N; i++) begin
            mem_l[i] = 3'($urandom_range(4, 7));
            mem_r[i] = 3'($urandom_range(4, 7));
        end
    endtask

    task automatic put_dark(input bit right, input int row, input int col);
        if (right) mem_r[row*W + col] = 3'($urandom_range(0, 3));
        else       mem_l[row*W + col] = 3'($urandom_range(0, 3));
    endtask

    task automatic fill_random();
        int c0;
        fill_bright();
        for (int r = 0; r < H; r++) begin
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    c0 = $urandom_range(0, W - 1);
                    put_dark(s[0], r, c0);
                    for (int c = c0 + 1; c < W; c++)
                        if ($urandom_range(0, 7) == 0) put_dark(s[0], r, c);
                end
            end
        end
    endtask

    // Reference: first dark column per row, mean offset over rows seen in both images.
    task automatic model();
        int sum;
        int rows;
        int fl;
        int fr;
        sum  = 0;
        rows = 0;
        for (int r = 0; r < H; r++) begin
            fl = -1;
            fr = -1;
            for (int c = 0; c < W; c++) begin
                if (fl < 0 && mem_l[r*W + c] <= 3'd3) fl = c;
                if (fr < 0 && mem_r[r*W + c] <= 3'd3) fr = c;
            end
            if (fl >= 0 && fr >= 0) begin
                sum  += fl - fr;
                rows += 1;
            end
        end
        exp_rows = rows;
        exp_ok   = (rows >= 8) ? 1 : 0;
        exp_disp = exp_ok ? sum / rows : 0;
        exp_lat  = N + RD_LAT + 2 + (exp_ok ? 12 : 0);
    endtask

    task automatic run(input string tag, input bit poke);
        int dv_cyc;
        int dv_n;
        int rd_n;
        int addr_err;
        int got_disp;
        int got_rows;
        int got_ok;
        int busy1;
        int busy_dv;
        model();
        dv_cyc = -1; dv_n = 0; rd_n = 0; addr_err = 0;
        got_disp = 0; got_rows = 0; got_ok = 0; busy1 = 0; busy_dv = 1;
        @(negedge sysclk);
        start = 1'b1;
        for (int cyc = 1; cyc <= exp_lat + 8; cyc++) begin
            @(negedge sysclk);
            start = poke && (cyc == 400);
            if (cyc == 1) busy1 = int'(busy);
            if (rden) begin
                if (int'(rdaddr) != rd_n) addr_err++;
                rd_n++;
            end
            if (disp_valid) begin
                dv_n++;
                if (dv_cyc < 0) begin
                    dv_cyc   = cyc;
                    got_disp = int'($signed(disparity));
                    got_rows = int'(rows_used);
                    got_ok   = int'(disp_ok);
                    busy_dv  = int'(busy);
                end
            end
        end
        check({tag, " latency"},   dv_cyc,   exp_lat);
        check({tag, " dv_count"},  dv_n,     1);
        check({tag, " disparity"}, got_disp, exp_disp);
        check({tag, " rows_used"}, got_rows, exp_rows);
        check({tag, " disp_ok"},   got_ok,   exp_ok);
        check({tag, " busy_c1"},   busy1,    1);
        check({tag, " busy_dv"},   busy_dv,  0);
        check({tag, " rden_cnt"},  rd_n,     N);
        check({tag, " addr_seq"},  addr_err, 0);
        check({tag, " held"},      $signed(disparity), exp_disp);
        check({tag, " idle"},      busy,     0);
    endtask

    initial begin
        int dv_seen;
        fill_bright();
        repeat (3) @(negedge sysclk);
        check("rst rdaddr",     rdaddr,     0);
        check("rst rden",       rden,       0);
        check("rst busy",       busy,       0);
        check("rst disp_valid", disp_valid, 0);
        check("rst disparity",  $signed(disparity), 0);
        check("rst rows_used",  rows_used,  0);
        check("rst disp_ok",    disp_ok,    0);
        resetc = 1'b1;
        repeat (2) @(negedge sysclk);

        // All rows: left 40, right 30.
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 40); put_dark(1, r, 30); end
        run("plus10", 0);

        // Right dark in only 6 rows: below the row minimum.
        fill_bright();
        for (int r = 0; r < H; r++) put_dark(0, r, $urandom_range(0, W - 1));
        for (int r = 0; r < 6; r++) put_dark(1, r, 10);
        run("few_rows", 0);

        // Nine rows: left 20, right 25.
        fill_bright();
        for (int r = 0; r < 9; r++) begin put_dark(0, r, 20); put_dark(1, r, 25); end
        run("minus5", 0);

        // Alternating +3/+4, then mirrored: truncation toward zero.
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 13 + (r % 2)); put_dark(1, r, 10); end
        run("trunc_pos", 0);
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(1, r, 13 + (r % 2)); put_dark(0, r, 10); end
        run("trunc_neg", 0);

        // Row 7 has a later dark pixel on the left that must be ignored.
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 30); put_dark(1, r, 28); end
        for (int c = 0; c < W; c++) mem_l[7*W + c] = 3'($urandom_range(4, 7));
        put_dark(0, 7, 10); put_dark(0, 7, 60);
        for (int c = 0; c < W; c++) mem_r[7*W + c] = 3'($urandom_range(4, 7));
        put_dark(1, 7, 5);
        run("first_dark", 0);

        // Column extremes: +78 and -78.
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 78); put_dark(1, r, 0); end
        run("edge_pos", 0);
        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 0); put_dark(1, r, 78); end
        run("edge_neg", 0);

        // Random images, one with a start pulse mid-scan.
        fill_random(); run("rand0", 0);
        fill_random(); run("rand1", 1);
        fill_random(); run("rand2", 0);

        // Reset in the middle of a scan.
        fill_random();
        @(negedge sysclk); start = 1'b1;
        @(negedge sysclk); start = 1'b0;
        repeat (300) @(negedge sysclk);
        resetc = 1'b0;
        #1;
        check("midrst rdaddr",     rdaddr,     0);
        check("midrst rden",       rden,       0);
        check("midrst busy",       busy,       0);
        check("midrst disp_valid", disp_valid, 0);
        check("midrst disparity",  $signed(disparity), 0);
        check("midrst rows_used",  rows_used,  0);
        check("midrst disp_ok",    disp_ok,    0);
        repeat (2) @(negedge sysclk);
        resetc = 1'b1;
        dv_seen = 0;
        repeat (1400) begin
            @(negedge sysclk);
            if (disp_valid || busy) dv_seen++;
        end
        check("midrst quiet", dv_seen, 0);

        fill_bright();
        for (int r = 0; r < H; r++) begin put_dark(0, r, 40); put_dark(1, r, 30); end
        run("after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
